// File: rtl/ld_power_sequencer.sv
// Supervisory power sequencer for the laser-diode current driver: sequences
// SW_ON/LD_ON/I_set and generates the C_out step tick that paces the driver's ramp.
module ld_power_sequencer #(
  parameter int TICK_DIV      = 1000,
  parameter int SETTLE_CYC    = 16,
  parameter int TIMEOUT_TICKS = 2048,
  parameter int I_OFF_THR     = 10
) (
  input  logic        CLK,
  input  logic        Clrn,
  input  logic        start_req,
  input  logic        stop_req,
  input  logic        clear_fault,
  input  logic        interlock_ok,
  input  logic [12:0] I_target,
  input  logic [12:0] I_out_fb,
  input  logic        Start_C,
  input  logic        Clr_C,
  output logic        SW_ON,
  output logic        LD_ON,
  output logic [12:0] I_set,
  output logic        C_out,
  output logic        ready,
  output logic        busy,
  output logic        fault,
  output logic [2:0]  state
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYC);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_TICKS);
  localparam logic [12:0]   OFF_THR   = 13'(I_OFF_THR);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_RAMP   = 3'd2,
    ST_RUN    = 3'd3,
    ST_SHUTDN = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [12:0]     i_set_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [TW-1:0]   tmo_q, tmo_d, tmo_inc;
  logic [PW-1:0]   presc_q;
  logic            tmo_hit, cur_off;

  // Step-tick prescaler; Clr_C outranks Start_C.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge Clrn) begin
    if (!Clrn) begin
      presc_q <= '0;
      C_out   <= 1'b0;
    end else if (Clr_C || !Start_C) begin
      presc_q <= '0;
      C_out   <= 1'b0;
    end else if (presc_q == PRESC_MAX) begin
      presc_q <= '0;
      C_out   <= 1'b1;
    end else begin
      presc_q <= presc_q + PW'(1);
      C_out   <= 1'b0;
    end
  end

  assign cur_off = (I_out_fb <= OFF_THR);
  assign tmo_inc = (C_out && tmo_q != TMO_MAX) ? tmo_q + TW'(1) : tmo_q;
  assign tmo_hit = (tmo_inc >= TMO_MAX);

  // NOTE: every signal written below gets a default first, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    i_set_d  = I_set;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_req && !stop_req && interlock_ok && I_target != 13'd0 && cur_off) begin
          state_d  = ST_ARM;
          i_set_d  = I_target;
          settle_d = SETTLE_LD;
        end
      end
      ST_ARM: begin
        if (!interlock_ok) begin
          state_d = ST_FAULT;
        end else if (stop_req) begin
          state_d = ST_SHUTDN;
          tmo_d   = '0;
        end else if (settle_q <= SW'(1)) begin
          state_d  = ST_RAMP;
          settle_d = '0;
          tmo_d    = '0;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      ST_RAMP: begin
        tmo_d = tmo_inc;
        if (!interlock_ok) begin
          state_d = ST_FAULT;
        end else if (stop_req) begin
          state_d = ST_SHUTDN;
          tmo_d   = '0;
        end else if (I_out_fb >= I_set) begin
          // Reaching setpoint beats a simultaneous timeout.
          state_d = ST_RUN;
        end else if (tmo_hit) begin
          state_d = ST_FAULT;
        end
      end
      ST_RUN: begin
        if (!interlock_ok) begin
          state_d = ST_FAULT;
        end else if (stop_req) begin
          state_d = ST_SHUTDN;
          tmo_d   = '0;
        end else if (I_target != I_set && I_target != 13'd0) begin
          i_set_d = I_target;
        end
      end
      ST_SHUTDN: begin
        tmo_d = tmo_inc;
        if (!interlock_ok) begin
          state_d = ST_FAULT;
        end else if (cur_off) begin
          state_d = ST_IDLE;
          i_set_d = 13'd0;
        end else if (tmo_hit) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (clear_fault && interlock_ok && cur_off) begin
          state_d = ST_IDLE;
          i_set_d = 13'd0;
        end
      end
      default: state_d = ST_FAULT;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge CLK or negedge Clrn) begin
    if (!Clrn) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      tmo_q    <= '0;
      I_set    <= 13'd0;
      SW_ON    <= 1'b0;
      LD_ON    <= 1'b0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      I_set    <= i_set_d;
      SW_ON    <= (state_d inside {ST_ARM, ST_RAMP, ST_RUN, ST_SHUTDN});
      LD_ON    <= (state_d inside {ST_RAMP, ST_RUN});
      ready    <= (state_d == ST_RUN);
      busy     <= !(state_d inside {ST_IDLE, ST_FAULT});
      fault    <= (state_d == ST_FAULT);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_ld_power_sequencer.sv
// Directed bench for ld_power_sequencer: expected outputs go through a scoreboard
// queue and are compared one microsecond-free step (#1) after each rising edge.
module tb_ld_power_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_ARM = 3'd1, S_RAMP = 3'd2,
                         S_RUN = 3'd3, S_SHUTDN = 3'd4, S_FAULT = 3'd5;

  logic        CLK = 1'b0;
  logic        Clrn;
  logic        start_req, stop_req, clear_fault, interlock_ok;
  logic [12:0] I_target, I_out_fb;
  logic        Start_C, Clr_C;
  logic        SW_ON, LD_ON, C_out, ready, busy, fault;
  logic [12:0] I_set;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  bit model_en = 1'b0;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic        sw, ld, rdy, bsy, flt;
    logic [12:0] iset;
  } exp_t;
  exp_t sb[$];

  ld_power_sequencer #(
    .TICK_DIV(4), .SETTLE_CYC(3), .TIMEOUT_TICKS(8), .I_OFF_THR(10)
  ) dut (
    .CLK(CLK), .Clrn(Clrn), .start_req(start_req), .stop_req(stop_req),
    .clear_fault(clear_fault), .interlock_ok(interlock_ok), .I_target(I_target),
    .I_out_fb(I_out_fb), .Start_C(Start_C), .Clr_C(Clr_C), .SW_ON(SW_ON),
    .LD_ON(LD_ON), .I_set(I_set), .C_out(C_out), .ready(ready), .busy(busy),
    .fault(fault), .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected outputs follow from the state alone, plus the setpoint.
  task automatic push_exp(input string tag, input logic [2:0] st, input logic [12:0] iset);
    exp_t e;
    e.tag  = tag;
    e.st   = st;
    e.sw   = (st == S_ARM || st == S_RAMP || st == S_RUN || st == S_SHUTDN);
    e.ld   = (st == S_RAMP || st == S_RUN);
    e.rdy  = (st == S_RUN);
    e.bsy  = e.sw;
    e.flt  = (st == S_FAULT);
    e.iset = iset;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, ".state"}, 13'(state), 13'(e.st));
    chk({e.tag, ".SW_ON"}, 13'(SW_ON), 13'(e.sw));
    chk({e.tag, ".LD_ON"}, 13'(LD_ON), 13'(e.ld));
    chk({e.tag, ".ready"}, 13'(ready), 13'(e.rdy));
    chk({e.tag, ".busy"},  13'(busy),  13'(e.bsy));
    chk({e.tag, ".fault"}, 13'(fault), 13'(e.flt));
    chk({e.tag, ".I_set"}, I_set, e.iset);
  endtask

  task automatic expect_now(input string tag, input logic [2:0] st, input logic [12:0] iset);
    push_exp(tag, st, iset);
    pop_check();
  endtask

  // One clock step; the behavioural driver moves its output 25 codes per C_out tick.
  task automatic tick();
    int fb, tgt;
    @(posedge CLK);
    #1;
    if (model_en && C_out) begin
      fb  = int'(I_out_fb);
      tgt = LD_ON ? int'(I_set) : 0;
      if (fb < tgt)      fb = (fb + 25 > tgt) ? tgt : fb + 25;
      else if (fb > tgt) fb = (fb - 25 < tgt) ? tgt : fb - 25;
      I_out_fb = 13'(fb);
    end
  endtask

  task automatic start_to_ramp(input logic [12:0] tgt, input string tag);
    I_target  = tgt;
    start_req = 1'b1;
    tick();
    expect_now({tag, "_arm1"}, S_ARM, tgt);
    start_req = 1'b0;
    tick();
    expect_now({tag, "_arm2"}, S_ARM, tgt);
    tick();
    expect_now({tag, "_arm3"}, S_ARM, tgt);
    tick();
    expect_now({tag, "_ramp"}, S_RAMP, tgt);
  endtask

  initial begin
    int n;
    Clrn = 1'b0; start_req = 1'b0; stop_req = 1'b0; clear_fault = 1'b0;
    interlock_ok = 1'b1; I_target = 13'd0; I_out_fb = 13'd0;
    Start_C = 1'b0; Clr_C = 1'b0;
    tick();
    tick();
    expect_now("reset", S_IDLE, 13'd0);
    chk("reset.C_out", 13'(C_out), 13'd0);
    Clrn = 1'b1;
    tick();
    expect_now("idle_hold", S_IDLE, 13'd0);

    // Normal start with the driver model; prescaler starts with the request.
    model_en = 1'b1;
    Start_C  = 1'b1;
    start_to_ramp(13'd100, "norm");
    chk("norm.tick_at_ramp", 13'(C_out), 13'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("norm.tick_gap", 13'(C_out), 13'd0);
    end
    tick();
    chk("norm.tick_period", 13'(C_out), 13'd1);
    for (int i = 0; i < 60 && state != S_RUN; i++) tick();
    expect_now("norm_run", S_RUN, 13'd100);
    I_target = 13'd80;
    tick();
    expect_now("run_retrack", S_RUN, 13'd80);
    I_target = 13'd0;
    tick();
    expect_now("run_zero_target", S_RUN, 13'd80);

    // Stop from RUN and ramp down across the off threshold.
    model_en = 1'b0;
    I_out_fb = 13'd100;
    stop_req = 1'b1;
    tick();
    expect_now("stop_shutdn", S_SHUTDN, 13'd80);
    stop_req = 1'b0;
    I_out_fb = 13'd11;
    tick();
    expect_now("shutdn_above_thr", S_SHUTDN, 13'd80);
    I_out_fb = 13'd10;
    tick();
    expect_now("shutdn_idle", S_IDLE, 13'd0);
    I_target  = 13'd80;
    start_req = 1'b1;
    stop_req  = 1'b1;
    tick();
    expect_now("start_and_stop", S_IDLE, 13'd0);
    start_req = 1'b0;
    stop_req  = 1'b0;

    // Stuck ramp: feedback never rises, so the 8th tick in RAMP faults.
    I_out_fb = 13'd0;
    start_to_ramp(13'd100, "stuck");
    n = 0;
    if (C_out) n++;
    for (int i = 0; i < 200 && n < 8; i++) begin
      tick();
      if (state != S_RAMP) break;
      if (C_out) n++;
    end
    chk("stuck.ticks_before_fault", 13'(n), 13'd8);
    expect_now("stuck_8th_tick", S_RAMP, 13'd100);
    tick();
    expect_now("stuck_fault", S_FAULT, 13'd100);
    clear_fault = 1'b1;
    tick();
    expect_now("stuck_clear", S_IDLE, 13'd0);
    clear_fault = 1'b0;

    // Interlock drop in RUN, then fault-clear qualifiers.
    start_to_ramp(13'd50, "ilk");
    I_out_fb = 13'd50;
    tick();
    expect_now("ilk_run", S_RUN, 13'd50);
    interlock_ok = 1'b0;
    tick();
    expect_now("ilk_fault", S_FAULT, 13'd50);
    clear_fault = 1'b1;
    I_out_fb    = 13'd0;
    tick();
    expect_now("clear_no_ilk", S_FAULT, 13'd50);
    interlock_ok = 1'b1;
    I_out_fb     = 13'd50;
    tick();
    expect_now("clear_fb_high", S_FAULT, 13'd50);
    I_out_fb = 13'd10;
    tick();
    expect_now("clear_ok", S_IDLE, 13'd0);
    clear_fault = 1'b0;

    // Tick clear when the prescaler sits at 2, then Start_C low.
    Clr_C = 1'b1;
    tick();
    chk("clr.hold", 13'(C_out), 13'd0);
    Clr_C = 1'b0;
    tick();
    chk("clr.p1", 13'(C_out), 13'd0);
    tick();
    chk("clr.p2", 13'(C_out), 13'd0);
    Clr_C = 1'b1;
    tick();
    chk("clr.pulse", 13'(C_out), 13'd0);
    Clr_C = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clr.after_gap", 13'(C_out), 13'd0);
    end
    tick();
    chk("clr.after_tick", 13'(C_out), 13'd1);
    Start_C = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (C_out) n++;
    end
    chk("startc_low.no_ticks", 13'(n), 13'd0);

    // Asynchronous reset in the middle of RAMP.
    Start_C  = 1'b1;
    I_out_fb = 13'd0;
    start_to_ramp(13'd100, "rst");
    tick();
    #3 Clrn = 1'b0;
    #1;
    expect_now("rst_async", S_IDLE, 13'd0);
    chk("rst_async.C_out", 13'(C_out), 13'd0);
    #2 Clrn = 1'b1;
    tick();
    expect_now("rst_release", S_IDLE, 13'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ld_power_sequencer.md
Name: ld_power_sequencer

Overview:
- Supervisory controller for the laser-diode current driver.
- Drives the driver's SW_ON, LD_ON and I_set, and acts as the ramp-step timebase: C_out is generated in response to the driver's Start_C/Clr_C.
- Sequences power-up, settle, ramp, run and shutdown, with ramp timeout and interlock fault handling.
- Sits between the user/control logic and the driver.

Parameters:
- TICK_DIV, 1000: CLK cycles per C_out step tick (minimum 2).
- SETTLE_CYC, 16: cycles SW_ON is held before LD_ON asserts.
- TIMEOUT_TICKS, 2048: maximum C_out ticks allowed in RAMP or SHUTDN before FAULT.
- I_OFF_THR, 10: I_out_fb at or below this value counts as "current off".

Ports:
- CLK  in  1  clock
- Clrn  in  1  reset, asynchronous, active-low
- start_req  in  1  level; request laser on
- stop_req  in  1  level; request laser off
- clear_fault  in  1  level; leave FAULT
- interlock_ok  in  1  1 = safe to emit
- I_target  in  13  requested current code
- I_out_fb  in  13  driver output current (feedback)
- Start_C  in  1  driver count-enable request
- Clr_C  in  1  driver count-clear request
- SW_ON  out  1  driver master switch
- LD_ON  out  1  driver laser enable
- I_set  out  13  driver setpoint
- C_out  out  1  one-cycle step tick to driver
- ready  out  1  current at setpoint (RUN)
- busy  out  1  state is not IDLE or FAULT
- fault  out  1  state is FAULT
- state  out  3  encoded state

Behaviour:
- All outputs are registered.
- Reset (Clrn=0, asynchronous): state=IDLE, all outputs 0, I_set=0, all counters 0.
- States: IDLE=0, ARM=1, RAMP=2, RUN=3, SHUTDN=4, FAULT=5. Unused codes go to FAULT.
- Transitions are evaluated each rising edge; outputs reflect the new state on the same edge.
- Global rule: interlock_ok=0 in ARM, RAMP, RUN or SHUTDN → FAULT next edge. This overrides every other condition.
- IDLE: SW_ON=0, LD_ON=0.
  - Go to ARM when start_req=1, stop_req=0, interlock_ok=1, I_target!=0 and I_out_fb<=I_OFF_THR.
  - On that edge, latch I_set←I_target and load the settle counter.
  - start_req together with stop_req: stay in IDLE.
- ARM: SW_ON=1, LD_ON=0.
  - The settle counter counts SETTLE_CYC cycles, then → RAMP with the tick-timeout counter cleared.
  - stop_req=1 → SHUTDN.
- RAMP: SW_ON=1, LD_ON=1.
  - Each C_out pulse increments the timeout counter.
  - I_out_fb>=I_set → RUN.
  - Timeout counter reaches TIMEOUT_TICKS → FAULT.
  - stop_req → SHUTDN.
  - If the RUN condition and the timeout occur on the same edge, RUN wins.
- RUN: SW_ON=1, LD_ON=1, ready=1.
  - I_target!=I_set and I_target!=0: I_set←I_target next edge; the driver retracks.
  - I_target=0 is ignored.
  - stop_req → SHUTDN.
- SHUTDN: SW_ON=1, LD_ON=0; the driver ramps down.
  - Timeout counter is cleared on entry and counts C_out.
  - I_out_fb<=I_OFF_THR → IDLE (SW_ON=0, I_set=0).
  - Timeout → FAULT.
- FAULT: SW_ON=0, LD_ON=0, I_set unchanged, fault=1; the driver self-ramps down.
  - Go to IDLE when clear_fault=1, interlock_ok=1 and I_out_fb<=I_OFF_THR. I_set←0 on that edge.
- Tick generator (active in every state):
  - Prescaler range is 0..TICK_DIV-1.
  - Clr_C=1: prescaler←0, C_out=0 (Clr_C has priority over Start_C).
  - Start_C=0: prescaler held at 0, C_out=0.
  - Start_C=1 and Clr_C=0: prescaler increments. At TICK_DIV-1 it wraps to 0 and C_out=1 for exactly one cycle.
  - First tick arrives TICK_DIV cycles after Start_C rises or Clr_C falls.
- Counters saturate; they never wrap.
- I_set changes only in the cases stated above.

Test Plan:
- Setup for all scenarios: TICK_DIV=4, SETTLE_CYC=3, TIMEOUT_TICKS=8, I_OFF_THR=10.
- Reset mid-RAMP → state=0, SW_ON=LD_ON=C_out=ready=0, I_set=0 immediately (asynchronous).
- Normal start: I_target=100, start_req=1, interlock_ok=1, behavioural driver model.
  - → ARM for 3 cycles with SW_ON=1, then RAMP with LD_ON=1.
  - C_out every 4th cycle while Start_C=1.
  - I_out_fb reaches 100 → RUN with ready=1.
  - Then I_target=80 → I_set=80 next edge.
- Stuck ramp: I_out_fb held at 0 in RAMP → FAULT on the 8th C_out.
  - SW_ON=0, fault=1.
  - clear_fault=1 with I_out_fb=0 → IDLE.
- Interlock drop: interlock_ok=0 in RUN → FAULT next edge.
  - clear_fault is ignored while interlock_ok=0 or I_out_fb=50.
- Stop: stop_req in RUN → SHUTDN (SW_ON=1, LD_ON=0).
  - I_out_fb falls to 10 → IDLE, SW_ON=0.
  - start_req together with stop_req in IDLE → stays IDLE.
- Tick clear: Clr_C pulse for 1 cycle when the prescaler is at 2 → no C_out.
  - Next C_out occurs exactly 4 cycles after Clr_C deasserts.
  - Start_C=0 → no C_out at all.
